// File: rtl/light_phase_scheduler.sv
// light_phase_scheduler: traffic phase FSM timed by divider edges; in: en ped_req emergency div_in, out: freq div_rst led_g/y/r walk ped_ack state
module light_phase_scheduler #(
  parameter logic [3:0] BASE_FREQ = 4'd1,
  parameter logic [3:0] BLINK_FREQ = 4'd4,
  parameter int unsigned G_EDGES = 5,
  parameter int unsigned MIN_G_EDGES = 2,
  parameter int unsigned Y_EDGES = 4,
  parameter int unsigned R_EDGES = 3,
  parameter int unsigned W_EDGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       emergency,
  input  logic       div_in,
  output logic [3:0] freq,
  output logic       div_rst,
  output logic       led_g,
  output logic       led_y,
  output logic       led_r,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, GREEN = 3'd1, YELLOW = 3'd2, RED = 3'd3, WALK = 3'd4, EMERG = 3'd5} state_t;
  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_freq;
  logic       r_ped, r_div_q, r_div_rst, r_led_g, r_led_y, r_led_r, r_walk, r_ack;
  state_t     w_nxt;
  logic       w_edge, w_chg, w_divq, w_ped_set;
  logic [7:0] w_inc;
  always_comb begin
    w_edge = div_in & ~r_div_q & ~r_div_rst;
    w_inc = r_cnt + 8'd1;
    w_nxt = state_t'(r_state);
    if (!en || r_state > EMERG) w_nxt = IDLE;
    else if (emergency && r_state != IDLE) w_nxt = EMERG;
    else case (r_state)
      IDLE:   w_nxt = GREEN;
      GREEN:  w_nxt = (w_edge && (w_inc == 8'(G_EDGES) || (r_ped && w_inc >= 8'(MIN_G_EDGES)))) ? YELLOW : GREEN;
      YELLOW: w_nxt = (w_edge && w_inc == 8'(Y_EDGES)) ? (r_ped ? WALK : RED) : YELLOW;
      RED:    w_nxt = (w_edge && w_inc == 8'(R_EDGES)) ? GREEN : RED;
      WALK:   w_nxt = (w_edge && w_inc == 8'(W_EDGES)) ? GREEN : WALK;
      EMERG:  w_nxt = RED;
      default: w_nxt = IDLE;
    endcase
    w_chg = w_nxt != r_state;
    w_divq = w_chg ? 1'b0 : div_in;
    w_ped_set = ped_req && (r_state == GREEN || r_state == YELLOW || r_state == RED || r_state == EMERG);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_freq <= BASE_FREQ;
      r_ped <= 1'b0;
      r_div_q <= 1'b0;
      r_div_rst <= 1'b0;
      r_led_g <= 1'b0;
      r_led_y <= 1'b0;
      r_led_r <= 1'b0;
      r_walk <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_chg ? 8'd0 : r_cnt + 8'(w_edge);
      r_freq <= w_chg ? ((w_nxt == YELLOW || w_nxt == EMERG) ? BLINK_FREQ : BASE_FREQ) : r_freq;
      r_ped <= (!en || (w_chg && w_nxt == WALK)) ? 1'b0 : (w_ped_set ? 1'b1 : r_ped);
      r_div_q <= w_divq;
      r_div_rst <= w_chg;
      r_led_g <= w_nxt == GREEN;
      r_led_y <= w_nxt == YELLOW && w_divq;
      r_led_r <= w_nxt == RED || w_nxt == WALK || (w_nxt == EMERG && w_divq);
      r_walk <= w_nxt == WALK;
      r_ack <= w_chg && w_nxt == WALK;
    end
  end
  assign state = r_state;
  assign freq = r_freq;
  assign div_rst = r_div_rst;
  assign led_g = r_led_g;
  assign led_y = r_led_y;
  assign led_r = r_led_r;
  assign walk = r_walk;
  assign ped_ack = r_ack;
endmodule

// File: tb/tb_light_phase_scheduler.sv
// tb_light_phase_scheduler: randomized scoreboard bench with a phase-countdown reference model
module tb_light_phase_scheduler;
  localparam int G = 5, MIN = 2, Y = 4, R = 3, W = 2;
  localparam logic [3:0] BASE = 4'd1, BLINK = 4'd4;
  logic clk = 0, rst = 1, en = 0, ped_req = 0, emergency = 0, div_in = 0;
  logic [3:0] freq;
  logic [2:0] state;
  logic div_rst, led_g, led_y, led_r, walk, ped_ack;
  logic [11:0] got, exp_v;
  logic [11:0] q[$];
  int tests = 0, fails = 0;
  int m_ph = 0, m_left = 0, dc = 0;
  logic [3:0] m_freq = BASE;
  bit m_ped = 0, m_prev = 0, m_blank = 0, dv = 0, d_hold = 1;

  light_phase_scheduler #(.BASE_FREQ(BASE), .BLINK_FREQ(BLINK), .G_EDGES(G), .MIN_G_EDGES(MIN),
    .Y_EDGES(Y), .R_EDGES(R), .W_EDGES(W)) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .emergency(emergency), .div_in(div_in),
    .freq(freq), .div_rst(div_rst), .led_g(led_g), .led_y(led_y), .led_r(led_r), .walk(walk),
    .ped_ack(ped_ack), .state(state));

  always #5 clk = ~clk;
  assign got = {state, freq, div_rst, led_g, led_y, led_r, walk, ped_ack};

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL outputs t=%0t: got {st,fq,drst,g,y,r,w,ack}=%b want %b", $time, got, exp_v);
      end
    end
  end

  function automatic int lim(input int p);
    return p == 1 ? G : p == 2 ? Y : p == 3 ? R : p == 4 ? W : 0;
  endfunction

  task automatic mstep(input bit r, input bit e_n, input bit pr, input bit em, input bit din);
    int nph;
    bit ev, chg;
    if (r) begin
      m_ph = 0; m_left = 0; m_freq = BASE; m_ped = 0; m_prev = 0; m_blank = 0;
      q.push_back({3'd0, BASE, 5'b0, 1'b0});
      return;
    end
    ev = din && !m_prev && !m_blank;
    nph = m_ph;
    if (m_ph > 5 || !e_n) nph = 0;
    else if (em && m_ph != 0) nph = 5;
    else if (m_ph == 0) nph = 1;
    else if (m_ph == 5) nph = 3;
    else if (ev) begin
      if (m_left == 1) nph = m_ph == 1 ? 2 : m_ph == 2 ? (m_ped ? 4 : 3) : 1;
      else if (m_ph == 1 && m_ped && G - m_left + 1 >= MIN) nph = 2;
    end
    chg = nph != m_ph;
    if (!e_n || (chg && nph == 4)) m_ped = 0;
    else if (pr && (m_ph == 1 || m_ph == 2 || m_ph == 3 || m_ph == 5)) m_ped = 1;
    if (chg) begin
      m_ph = nph; m_left = lim(nph); m_freq = (nph == 2 || nph == 5) ? BLINK : BASE;
      m_prev = 0; m_blank = 1;
    end else begin
      if (ev && m_left > 0) m_left--;
      m_prev = din; m_blank = 0;
    end
    q.push_back({3'(m_ph), m_freq, chg, m_ph == 1, m_ph == 2 && m_prev,
                 m_ph == 3 || m_ph == 4 || (m_ph == 5 && m_prev), m_ph == 4, chg && m_ph == 4});
  endtask

  task automatic tick(input bit r, input bit e_n, input bit pr, input bit em, input bit bad = 0);
    @(negedge clk);
    if (d_hold) begin dc = 0; dv = 0; end
    else begin
      dc++;
      if (dc >= (freq == BLINK ? 2 : 4)) begin dc = 0; dv = ~dv; end
    end
    d_hold = rst || div_rst;
    if (bad) begin
      force dut.r_state = 3'd7;
      #1 release dut.r_state;
      m_ph = 7;
    end
    rst = r; en = e_n; ped_req = pr; emergency = em; div_in = dv;
    mstep(r, e_n, pr, em, dv);
  endtask

  task automatic wait_ph(input int ph, input int left, input string nm);
    int n = 0;
    while (!(m_ph == ph && m_left == left) && n < 400) begin
      tick(0, 1, 0, 0);
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: timeout, model at ph=%0d left=%0d, want ph=%0d left=%0d", nm, m_ph, m_left, ph, left);
    end
  endtask

  initial begin
    bit em_lvl = 0;
    repeat (3) tick(1, 0, 0, 0);
    repeat (110) tick(0, 1, 0, 0);
    wait_ph(1, G - 1, "green_edge1");
    tick(0, 1, 1, 0);
    repeat (90) tick(0, 1, 0, 0);
    wait_ph(2, Y - 2, "yellow_edge2");
    repeat (20) tick(0, 1, 0, 1);
    repeat (60) tick(0, 1, 0, 0);
    wait_ph(3, R - 1, "red_edge1");
    repeat (3) tick(0, 0, 0, 0);
    repeat (60) tick(0, 1, 0, 0);
    wait_ph(1, G - 1, "green_again");
    tick(0, 1, 1, 0);
    wait_ph(4, W, "walk_entry");
    tick(0, 1, 0, 0);
    #2 rst = 1;
    #1;
    tests++;
    if (got !== {3'd0, BASE, 5'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_rst: got %b want %b", got, {3'd0, BASE, 5'b0, 1'b0});
    end
    void'(q.pop_back());
    mstep(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0);
    repeat (100) tick(0, 1, 0, 0);
    repeat (13) tick(0, 1, 0, 0);
    tick(0, 1, 0, 0, 1);
    repeat (80) tick(0, 1, 0, 0);
    repeat (3000) begin
      if ($urandom_range(0, 149) == 0) em_lvl = ~em_lvl;
      tick(0, $urandom_range(0, 299) != 0, $urandom_range(0, 24) == 0, em_lvl);
      if ($urandom_range(0, 599) == 0) tick(0, 1, 0, 0, 1);
    end
    repeat (2) tick(0, 1, 0, 0);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
